bwt_dram_req_arbiter: RTL and testbench
=======================================

# bwt_dram_req_arbiter

Shares the single BWT-extend DRAM request port (`DRAM_valid`, `addr_k`, `addr_l`) among `N_REQ` read-slot requesters in the SMEM pipeline. Requesters are served round-robin. The in-order response stream (`DRAM_get`) is routed back to the requester that issued the matching request, using a tag FIFO. The block sits between the per-read extension lanes and the DRAM interface that returns `cnt_*`/`cntl_*` occurrence data.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, requester index width, equal to clog2(`N_REQ`)
- `MAX_OUT`, 8, maximum number of outstanding DRAM requests; power of 2, at least 2
- `Clk_32UI`  in  1  clock; all logic is rising-edge
- `reset_BWT_extend`  in  1  asynchronous, active-high reset
- `req_valid`  in  `N_REQ`  bit i: requester i has a request pending
- `req_addr_k`  in  `N_REQ`*32  packed; requester i occupies bits [32i+31:32i]
- `req_addr_l`  in  `N_REQ`*32  packed, same layout as `req_addr_k`
- `req_ready`  out  `N_REQ`  one-hot grant (combinational); a request is transferred when `req_valid[i]` and `req_ready[i]` are both high
- `DRAM_valid`  out  1  registered; request issued this cycle
- `addr_k`  out  32  registered
- `addr_l`  out  32  registered
- `DRAM_get`  in  1  one response returned this cycle; responses arrive in issue order
- `rsp_valid`  out  `N_REQ`  registered one-hot; pulses for the owner of the response
- `outstanding`  out  clog2(`MAX_OUT`)+1  number of issued but unanswered requests
- `rsp_err`  out  1  sticky flag: `DRAM_get` arrived with no outstanding request

## Operation
- Registered state:
  - `rr_ptr` (ID_W bits)
  - tag FIFO: `MAX_OUT` entries of ID_W bits, with wr/rd pointers and a count
  - output registers
- Grant eligibility:
  - A grant is possible only when `outstanding < MAX_OUT`. The count is evaluated before any same-cycle pop, so the check is conservative.
  - When `outstanding == MAX_OUT`, all `req_ready` bits are 0.
- Round-robin:
  - Scan for the first requester with `req_valid` set, in order `rr_ptr+1`, `rr_ptr+2`, … modulo `N_REQ`.
  - Set `req_ready` for that index only. At most one grant per cycle.
- On a grant to requester i:
  - Latch `req_addr_k[i]` into `addr_k` and `req_addr_l[i]` into `addr_l`.
  - Set `DRAM_valid` to 1 for the next cycle.
  - Push i into the tag FIFO and set `rr_ptr` to i.
- With no grant: `DRAM_valid` = 0, and `addr_k`/`addr_l` hold their previous values.
- On `DRAM_get` = 1 with `outstanding > 0`:
  - Pop the FIFO head h.
  - Next cycle `rsp_valid` = one-hot(h); otherwise `rsp_valid` = 0.
- On `DRAM_get` = 1 with `outstanding == 0`:
  - No pop, `rsp_valid` = 0.
  - Set `rsp_err` to 1; it stays 1 until reset.
- Push and pop in the same cycle: `outstanding` is unchanged and both pointers advance.
- FIFO pointers wrap modulo `MAX_OUT`.
- A requester that deasserts `req_valid` before it is granted is skipped; no request is recorded for it.
- The arbiter does not check addresses (for example k > l); they are forwarded as-is.

## Timing
- Reset values:
  - `DRAM_valid`, `addr_k`, `addr_l`, `rsp_valid`, `outstanding`, `rsp_err`: 0
  - `rr_ptr` = `N_REQ`-1, so requester 0 has first priority
  - FIFO pointers: 0
- Reset asserted mid-operation discards every outstanding tag. Responses that arrive after reset release are treated as unmatched and set `rsp_err`.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr` and `outstanding` only. It does not depend on `DRAM_get`.
- Request latency: grant in cycle t gives `DRAM_valid` in cycle t+1.
- Response latency: `DRAM_get` in cycle t gives `rsp_valid` in cycle t+1.
- `outstanding` updates at the edge that ends the grant or `DRAM_get` cycle.
- Throughput: one request per cycle and one response per cycle, sustained.
- With k requesters continuously valid, each one receives exactly one grant in every k consecutive grants.

## Test plan
- Reset, then hold `req_valid` = 4'b0000 for 10 cycles -> all outputs stay 0 and `req_ready` = 0.
- `req_valid` = 4'b1111 held with `req_addr_k[i]` = 32'h100+i -> grant order 0,1,2,3,0,…; `DRAM_valid` high every cycle; `addr_k` sequence 100,101,102,103,100.
- Issue 3 requests from requesters 2,0,1, then pulse `DRAM_get` on 3 consecutive cycles -> `rsp_valid` = 4'b0100, 4'b0001, 4'b0010, one cycle after each `DRAM_get`; `outstanding` counts down 3,2,1,0.
- Fill to `MAX_OUT` = 8 with no responses -> `req_ready` = 0 while `outstanding` = 8. A single `DRAM_get` brings `outstanding` to 7 and grants resume the following cycle.
- At `outstanding` = 4, a grant and a `DRAM_get` in the same cycle -> `outstanding` stays 4; FIFO order preserved across the pointer wrap.
- `DRAM_get` with `outstanding` = 0 -> `rsp_err` = 1 and `rsp_valid` = 0. Asserting `reset_BWT_extend` mid-burst -> all outputs immediately 0 and `rsp_err` cleared.

Source files
------------

// File: rtl/bwt_dram_req_arbiter.sv
// bwt_dram_req_arbiter
//
// Shares the single BWT-extend DRAM request port among N_REQ read-slot
// requesters. Requests are granted round-robin, one per cycle. Because the
// DRAM returns responses in issue order, the owner index of each issued
// request goes into a tag FIFO. Each DRAM_get pops the head tag and routes
// the response pulse back to its owner.
//
// Ports
//   Clk_32UI          clock, rising edge
//   reset_BWT_extend  asynchronous active-high reset
//   req_valid         per-requester request pending
//   req_addr_k/_l     packed per-requester addresses, requester i at [32i+31:32i]
//   req_ready         one-hot combinational grant
//   DRAM_valid        registered request strobe toward DRAM
//   addr_k/addr_l     registered request addresses (held when idle)
//   DRAM_get          in-order response strobe from DRAM
//   rsp_valid         registered one-hot response owner pulse
//   outstanding       issued but unanswered request count
//   rsp_err           sticky: response arrived with nothing outstanding
module bwt_dram_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                      Clk_32UI,
    input  logic                      reset_BWT_extend,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*32-1:0]       req_addr_k,
    input  logic [N_REQ*32-1:0]       req_addr_l,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      DRAM_valid,
    output logic [31:0]               addr_k,
    output logic [31:0]               addr_l,
    input  logic                      DRAM_get,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      rsp_err
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  tag_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             can_grant;
    logic             found;
    logic             grant;
    logic             pop;
    logic [ID_W-1:0]  scan_id;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  head_id;
    logic [31:0]      sel_k;
    logic [31:0]      sel_l;

    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (id == ID_W'(i));
        end
        return oh;
    endfunction

    // Request select: scan rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ), first valid wins.
    // The count check ignores a same-cycle pop, so a full FIFO blocks grants
    // for one extra cycle but req_ready never depends on DRAM_get.
    always_comb begin
        found    = 1'b0;
        scan_id  = rr_ptr;
        grant_id = rr_ptr;
        for (int off = 1; off <= N_REQ; off++) begin
            scan_id = ID_W'((int'(rr_ptr) + off) % N_REQ);
            if (!found && req_valid[scan_id]) begin
                found    = 1'b1;
                grant_id = scan_id;
            end
        end
        can_grant = (outstanding < FULL_CNT);
        grant     = can_grant && found;
        req_ready = grant ? id_onehot(grant_id) : '0;
    end

    always_comb begin
        sel_k = '0;
        sel_l = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_k = req_addr_k[i*32 +: 32];
                sel_l = req_addr_l[i*32 +: 32];
            end
        end
    end

    assign head_id = tag_mem[rd_ptr];
    assign pop     = DRAM_get && (outstanding != '0);

    // Issue / response register stage
    always_ff @(posedge Clk_32UI or posedge reset_BWT_extend) begin
        if (reset_BWT_extend) begin
            rr_ptr      <= LAST_ID;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            DRAM_valid  <= 1'b0;
            addr_k      <= '0;
            addr_l      <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            DRAM_valid <= grant;
            if (grant) begin
                addr_k <= sel_k;
                addr_l <= sel_l;
                rr_ptr <= grant_id;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rsp_valid <= pop ? id_onehot(head_id) : '0;
            if (DRAM_get && (outstanding == '0)) begin
                rsp_err <= 1'b1;
            end
            case ({grant, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge Clk_32UI) begin
        if (grant) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

endmodule

// File: tb/tb_bwt_dram_req_arbiter.sv
module tb_bwt_dram_req_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int MAX_OUT = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*32-1:0]     req_addr_k = '0;
    logic [N_REQ*32-1:0]     req_addr_l = '0;
    logic [N_REQ-1:0]        req_ready;
    logic                    DRAM_valid;
    logic [31:0]             addr_k;
    logic [31:0]             addr_l;
    logic                    DRAM_get = 1'b0;
    logic [N_REQ-1:0]        rsp_valid;
    logic [$clog2(MAX_OUT):0] outstanding;
    logic                    rsp_err;

    always #5 clk = ~clk;

    bwt_dram_req_arbiter #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .Clk_32UI         (clk),
        .reset_BWT_extend (rst),
        .req_valid        (req_valid),
        .req_addr_k       (req_addr_k),
        .req_addr_l       (req_addr_l),
        .req_ready        (req_ready),
        .DRAM_valid       (DRAM_valid),
        .addr_k           (addr_k),
        .addr_l           (addr_l),
        .DRAM_get         (DRAM_get),
        .rsp_valid        (rsp_valid),
        .outstanding      (outstanding),
        .rsp_err          (rsp_err)
    );

    typedef struct {
        logic [3:0] v;
        logic       get;
        logic [3:0] rdy;
        int         out;
    } vec_t;

    typedef struct {
        logic        dv;
        logic [31:0] k;
        logic [31:0] l;
    } req_t;

    vec_t        tbl[$];
    req_t        req_q[$];
    logic [3:0]  rsp_q[$];
    int          tag_q[$];

    int          n_vec = 0;
    int          n_miss = 0;
    logic        exp_err = 1'b0;
    logic [31:0] last_k = '0;
    logic [31:0] last_l = '0;

    function automatic logic [31:0] k_of(input int i);
        return 32'(32'h100 + i);
    endfunction

    function automatic logic [31:0] l_of(input int i);
        return 32'(32'h2000 + i * 16);
    endfunction

    function automatic int idx_of(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    function automatic void add(input logic [3:0] v, input logic g, input logic [3:0] r, input int o);
        tbl.push_back('{v, g, r, o});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; drives one cycle and checks the result.
    task automatic run_cycle(input logic [3:0] v, input logic get, input logic [3:0] rdy, input int out);
        req_t       r;
        logic [3:0] rexp;
        int         g;
        req_valid = v;
        DRAM_get  = get;
        #1;
        chk("req_ready", 32'(req_ready), 32'(rdy));
        rexp = '0;
        if (get) begin
            if (tag_q.size() > 0) begin
                g    = tag_q.pop_front();
                rexp = 4'(1 << g);
            end else begin
                exp_err = 1'b1;
            end
        end
        rsp_q.push_back(rexp);
        r.dv = (rdy != 4'b0000);
        if (r.dv) begin
            g      = idx_of(rdy);
            last_k = k_of(g);
            last_l = l_of(g);
            tag_q.push_back(g);
        end
        r.k = last_k;
        r.l = last_l;
        req_q.push_back(r);
        @(posedge clk);
        #1;
        r    = req_q.pop_front();
        rexp = rsp_q.pop_front();
        chk("DRAM_valid", 32'(DRAM_valid), 32'(r.dv));
        chk("addr_k", addr_k, r.k);
        chk("addr_l", addr_l, r.l);
        chk("rsp_valid", 32'(rsp_valid), 32'(rexp));
        chk("outstanding", 32'(outstanding), 32'(out));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            req_addr_k[i*32 +: 32] = k_of(i);
            req_addr_l[i*32 +: 32] = l_of(i);
        end

        // idle after reset
        for (int i = 0; i < 10; i++) add(4'b0000, 1'b0, 4'b0000, 0);
        // all valid: round robin 0,1,2,3,0 then drain
        add(4'b1111, 1'b0, 4'b0001, 1);
        add(4'b1111, 1'b0, 4'b0010, 2);
        add(4'b1111, 1'b0, 4'b0100, 3);
        add(4'b1111, 1'b0, 4'b1000, 4);
        add(4'b1111, 1'b0, 4'b0001, 5);
        for (int i = 4; i >= 0; i--) add(4'b0000, 1'b1, 4'b0000, i);
        // requesters 2,0,1 then three responses
        add(4'b0100, 1'b0, 4'b0100, 1);
        add(4'b0001, 1'b0, 4'b0001, 2);
        add(4'b0010, 1'b0, 4'b0010, 3);
        add(4'b0000, 1'b1, 4'b0000, 2);
        add(4'b0000, 1'b1, 4'b0000, 1);
        add(4'b0000, 1'b1, 4'b0000, 0);
        // fill to MAX_OUT starting from requester 2
        add(4'b1111, 1'b0, 4'b0100, 1);
        add(4'b1111, 1'b0, 4'b1000, 2);
        add(4'b1111, 1'b0, 4'b0001, 3);
        add(4'b1111, 1'b0, 4'b0010, 4);
        add(4'b1111, 1'b0, 4'b0100, 5);
        add(4'b1111, 1'b0, 4'b1000, 6);
        add(4'b1111, 1'b0, 4'b0001, 7);
        add(4'b1111, 1'b0, 4'b0010, 8);
        add(4'b1111, 1'b0, 4'b0000, 8);
        add(4'b1111, 1'b1, 4'b0000, 7);
        add(4'b1111, 1'b0, 4'b0100, 8);
        for (int i = 7; i >= 0; i--) add(4'b0000, 1'b1, 4'b0000, i);
        // hold at 4 with simultaneous push and pop across the wrap
        add(4'b1111, 1'b0, 4'b1000, 1);
        add(4'b1111, 1'b0, 4'b0001, 2);
        add(4'b1111, 1'b0, 4'b0010, 3);
        add(4'b1111, 1'b0, 4'b0100, 4);
        add(4'b1111, 1'b1, 4'b1000, 4);
        add(4'b1111, 1'b1, 4'b0001, 4);
        add(4'b1111, 1'b1, 4'b0010, 4);
        add(4'b1111, 1'b1, 4'b0100, 4);
        add(4'b1111, 1'b1, 4'b1000, 4);
        for (int i = 3; i >= 0; i--) add(4'b0000, 1'b1, 4'b0000, i);
        // unmatched response, sticky error
        add(4'b0000, 1'b1, 4'b0000, 0);
        add(4'b0000, 1'b0, 4'b0000, 0);
        // start of a burst that reset will interrupt
        add(4'b1111, 1'b0, 4'b0001, 1);
        add(4'b1111, 1'b0, 4'b0010, 2);
        add(4'b1111, 1'b0, 4'b0100, 3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset DRAM_valid", 32'(DRAM_valid), 32'h0);
        chk("reset addr_k", addr_k, 32'h0);
        chk("reset addr_l", addr_l, 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset outstanding", 32'(outstanding), 32'h0);
        chk("reset rsp_err", 32'(rsp_err), 32'h0);

        foreach (tbl[i]) begin
            run_cycle(tbl[i].v, tbl[i].get, tbl[i].rdy, tbl[i].out);
        end

        // asynchronous reset in the middle of the burst
        req_valid = 4'b0000;
        DRAM_get  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst req_ready", 32'(req_ready), 32'h0);
        chk("midrst DRAM_valid", 32'(DRAM_valid), 32'h0);
        chk("midrst addr_k", addr_k, 32'h0);
        chk("midrst addr_l", addr_l, 32'h0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst outstanding", 32'(outstanding), 32'h0);
        chk("midrst rsp_err", 32'(rsp_err), 32'h0);
        tag_q.delete();
        req_q.delete();
        rsp_q.delete();
        exp_err = 1'b0;
        last_k  = '0;
        last_l  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // discarded tags: response after reset is unmatched
        run_cycle(4'b0000, 1'b1, 4'b0000, 0);
        // priority restarts at requester 0
        run_cycle(4'b1010, 1'b0, 4'b0010, 1);
        run_cycle(4'b0001, 1'b0, 4'b0001, 2);
        run_cycle(4'b0000, 1'b1, 4'b0000, 1);
        run_cycle(4'b0000, 1'b1, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
